// File: rtl/flow_ctrl_pkg.sv
// Shared constants and types for the round-robin channel arbiter.
//   N_CH   : number of requesters (power of two)
//   SEL_W  : grant index width, $clog2(N_CH)
//   DATA_W : channel word width
package flow_ctrl_pkg;

    localparam int N_CH   = 32;
    localparam int SEL_W  = $clog2(N_CH);
    localparam int DATA_W = 20;

    typedef enum logic {IDLE, XFER} arb_state_t;

    typedef logic [DATA_W-1:0] chan_word_t;

endpackage

// File: rtl/rr_channel_arbiter_if.sv
// Requester/output-channel bundle of the round-robin arbiter.
//   master : requester side + downstream sink (drives req, data_in, out_ready)
//   slave  : the arbiter (drives ack, gnt, gnt_idx, out_valid, out_data)
interface rr_channel_arbiter_if;
    import flow_ctrl_pkg::*;

    logic [N_CH-1:0]             req;
    chan_word_t [N_CH-1:0]       data_in;
    logic [N_CH-1:0]             ack;
    logic [N_CH-1:0]             gnt;
    logic [SEL_W-1:0]            gnt_idx;
    logic                        out_valid;
    chan_word_t                  out_data;
    logic                        out_ready;

    modport master (
        output req, data_in, out_ready,
        input  ack, gnt, gnt_idx, out_valid, out_data
    );

    modport slave (
        input  req, data_in, out_ready,
        output ack, gnt, gnt_idx, out_valid, out_data
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin winner search.
//   req       : per-channel request vector
//   ptr       : highest-priority index
//   win_idx   : first set request at or after ptr (wrapping)
//   win_valid : any request pending
module rr_priority_pick
    import flow_ctrl_pkg::*;
#(
    parameter int N  = N_CH,
    parameter int SW = SEL_W
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] win_idx,
    output logic          win_valid
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SW-1:0]  off;

    always_comb begin
        // Rotating right by ptr puts the highest-priority channel at bit 0,
        // so a plain lowest-set-bit encoder yields the offset from ptr.
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = SW'(i);
        end
        win_valid = |req;
        // Natural SW-bit overflow gives the modulo-N wrap.
        win_idx   = off + ptr;
    end

endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin arbiter sharing one DATA_W output channel among N_CH requesters.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : slave modport -- req/data_in in, ack (combinational one-hot
//               capture pulse), registered gnt/gnt_idx, out_valid/out_data
//               with out_ready back-pressure.
module rr_channel_arbiter
    import flow_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    rr_channel_arbiter_if.slave bus
);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q;
    logic [N_CH-1:0]  gnt_q;
    logic [SEL_W-1:0] gnt_idx_q;
    chan_word_t       out_data_q;

    logic [SEL_W-1:0] win_idx;
    logic             win_valid;
    logic             accept;
    logic             load;

    rr_priority_pick #(.N(N_CH), .SW(SEL_W)) u_pick (
        .req       (bus.req),
        .ptr       (ptr_q),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // out_valid is exactly "in XFER", so it is taken straight from the state.
    assign accept = (state_q == XFER) && bus.out_ready;
    assign load   = ((state_q == IDLE) || accept) && win_valid && !rst;

    always_comb begin
        state_d = state_q;
        bus.ack = '0;
        if (load) begin
            state_d = XFER;
            bus.ack = N_CH'(1) << win_idx;
        end else if (accept) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                out_data_q <= bus.data_in[win_idx];
                gnt_idx_q  <= win_idx;
                gnt_q      <= N_CH'(1) << win_idx;
                ptr_q      <= win_idx + SEL_W'(1);
            end else if (accept) begin
                // gnt_idx keeps the last select so the mux stays put.
                gnt_q <= '0;
            end
        end
    end

    assign bus.out_valid = (state_q == XFER);
    assign bus.out_data  = out_data_q;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;

endmodule
